// File: rtl/bcd_conv_scheduler.sv
// Shared binary-to-BCD converter: a round-robin arbiter hands one sequential
// double-dabble engine to NUM_REQ requesters, one conversion at a time.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-low
//   req      level request per requester
//   bin_in   packed binary values, requester k at [k*BIN_W +: BIN_W]
//   ack      one-cycle one-hot pulse: request accepted, value latched
//   done     one-cycle one-hot pulse: bcd_out valid for that requester
//   bcd_out  packed BCD result, most significant digit in the top nibble
//   gnt_id   index of the requester currently or last served
//   busy     high while a conversion is in progress (CONV and DONE)
module bcd_conv_scheduler #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned BIN_W   = 16,
   parameter int unsigned DIGITS  = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*BIN_W-1:0]   bin_in,
   output logic [NUM_REQ-1:0]         ack,
   output logic [NUM_REQ-1:0]         done,
   output logic [DIGITS*4-1:0]        bcd_out,
   output logic [$clog2(NUM_REQ)-1:0] gnt_id,
   output logic                       busy
);

   localparam int unsigned ID_W  = $clog2(NUM_REQ);
   localparam int unsigned BCD_W = DIGITS * 4;
   localparam int unsigned SR_W  = BCD_W + BIN_W;
   localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     last, last_nxt;
   logic [SR_W-1:0]     sr, sr_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [NUM_REQ-1:0]  ack_nxt, done_nxt;
   logic [BCD_W-1:0]    bcd_nxt;
   logic [ID_W-1:0]     gnt_nxt;
   logic                busy_nxt;

   logic [ID_W-1:0]     pick;
   logic [ID_W-1:0]     cand;
   logic                pick_found;
   logic [SR_W-1:0]     dab;
   logic                gnt_ok;
   logic [BIN_W-1:0]    bin_arr [NUM_REQ];

   // Unpack the flat input bus into one value per requester
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign bin_arr[k] = bin_in[k*BIN_W +: BIN_W];
   end

   // Guards against a corrupted grant index (only reachable when NUM_REQ is not a power of two)
   assign gnt_ok = ({1'b0, gnt_id} < (ID_W+1)'(NUM_REQ));

   // Round-robin pick: first requester set, searching upward from last+1
   always_comb begin
      pick_found = 1'b0;
      pick       = '0;
      cand       = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = ID_W'((32'(last) + i) % NUM_REQ);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick       = cand;
         end
      end
   end

   // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
   always_comb begin
      dab = sr;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (dab[BIN_W + 4*d +: 4] >= 4'd5) begin
            dab[BIN_W + 4*d +: 4] = dab[BIN_W + 4*d +: 4] + 4'd3;
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      sr_nxt    = sr;
      cnt_nxt   = cnt;
      ack_nxt   = '0;
      done_nxt  = '0;
      bcd_nxt   = bcd_out;
      gnt_nxt   = gnt_id;
      busy_nxt  = busy;

      case (state)
         S_IDLE: begin
            busy_nxt = 1'b0;
            if (pick_found) begin
               ack_nxt[pick] = 1'b1;
               gnt_nxt       = pick;
               sr_nxt        = SR_W'(bin_arr[pick]);
               cnt_nxt       = '0;
               state_nxt     = S_CONV;
               busy_nxt      = 1'b1;
            end
         end

         S_CONV: begin
            if (!gnt_ok) begin
               state_nxt = S_IDLE;
               busy_nxt  = 1'b0;
            end else begin
               sr_nxt  = {dab[SR_W-2:0], 1'b0};
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == CNT_W'(BIN_W - 1)) begin
                  state_nxt = S_DONE;
               end
            end
         end

         S_DONE: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
            if (gnt_ok) begin
               bcd_nxt          = sr[SR_W-1 -: BCD_W];
               done_nxt[gnt_id] = 1'b1;
               last_nxt         = gnt_id;
            end
         end

         default: begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any conversion in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         last    <= ID_W'(NUM_REQ - 1);
         sr      <= '0;
         cnt     <= '0;
         ack     <= '0;
         done    <= '0;
         bcd_out <= '0;
         gnt_id  <= '0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         last    <= last_nxt;
         sr      <= sr_nxt;
         cnt     <= cnt_nxt;
         ack     <= ack_nxt;
         done    <= done_nxt;
         bcd_out <= bcd_nxt;
         gnt_id  <= gnt_nxt;
         busy    <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Testbench for bcd_conv_scheduler: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a transaction-level reference model
// (round-robin pick, fixed BIN_W+1 latency, decimal digits by division).
module tb_bcd_conv_scheduler;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned BIN_W   = 16;
   localparam int unsigned DIGITS  = 5;
   localparam int unsigned ID_W    = 2;
   localparam int unsigned BCD_W   = DIGITS * 4;
   localparam int unsigned LAT     = BIN_W + 1;

   logic                     clk;
   logic                     reset;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*BIN_W-1:0] bin_in;
   logic [NUM_REQ-1:0]       ack;
   logic [NUM_REQ-1:0]       done;
   logic [BCD_W-1:0]         bcd_out;
   logic [ID_W-1:0]          gnt_id;
   logic                     busy;

   bcd_conv_scheduler #(
      .NUM_REQ (NUM_REQ),
      .BIN_W   (BIN_W),
      .DIGITS  (DIGITS)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .bin_in  (bin_in),
      .ack     (ack),
      .done    (done),
      .bcd_out (bcd_out),
      .gnt_id  (gnt_id),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
      logic [BCD_W-1:0] r;
      int unsigned rest;
      r    = '0;
      rest = v;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(rest % 10);
         rest        = rest / 10;
      end
      return r;
   endfunction

   function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Reference model state
   int unsigned        m_cnt;
   int                 m_last;
   int                 m_g;
   int                 m_gid;
   logic [BIN_W-1:0]   m_val;
   logic [BCD_W-1:0]   m_bcd;
   logic [NUM_REQ-1:0] e_ack, e_done;
   int unsigned        cyc = 0;
   int                 g_log[$];
   int unsigned        g_cyc[$];

   // Per-cycle model step and full output comparison
   always begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         m_cnt  = 0;
         m_last = NUM_REQ - 1;
         m_g    = 0;
         m_gid  = 0;
         m_bcd  = '0;
         #1;
         chk("rst_ack",  32'(ack),     32'd0);
         chk("rst_done", 32'(done),    32'd0);
         chk("rst_bcd",  32'(bcd_out), 32'd0);
         chk("rst_gnt",  32'(gnt_id),  32'd0);
         chk("rst_busy", 32'(busy),    32'd0);
      end else begin
         cyc++;
         e_ack  = '0;
         e_done = '0;
         if (m_cnt == 0) begin
            if (req != '0) begin
               int idx;
               idx = 0;
               for (int i = 1; i <= NUM_REQ; i++) begin
                  idx = (m_last + i) % NUM_REQ;
                  if (req[idx]) break;
               end
               e_ack[idx] = 1'b1;
               m_g        = idx;
               m_gid      = idx;
               m_val      = bin_in[idx*BIN_W +: BIN_W];
               m_cnt      = LAT;
            end
         end else begin
            m_cnt--;
            if (m_cnt == 0) begin
               e_done[m_g] = 1'b1;
               m_bcd       = to_bcd(32'(m_val));
               m_last      = m_g;
            end
         end
         #1;
         chk("ack",  32'(ack),     32'(e_ack));
         chk("done", 32'(done),    32'(e_done));
         chk("bcd",  32'(bcd_out), 32'(m_bcd));
         chk("gnt",  32'(gnt_id),  32'(m_gid));
         chk("busy", 32'(busy),    32'(m_cnt != 0));
         if (ack != '0) begin
            g_log.push_back(onehot_idx(ack));
            g_cyc.push_back(cyc);
         end
      end
   end

   task automatic set_bin(input int k, input int unsigned v);
      bin_in[k*BIN_W +: BIN_W] = BIN_W'(v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      chk("idle_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_ack(input int k, output bit ok);
      ok = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (ack[k]) begin
            ok = 1;
            break;
         end
      end
   endtask

   task automatic wait_done(input int k, output bit ok, output int lat);
      ok  = 0;
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (done[k]) begin
            ok  = 1;
            lat = i;
            break;
         end
      end
   endtask

   // One isolated conversion on requester k with a literal expected result
   task automatic run_one(input int k, input int unsigned v, input logic [BCD_W-1:0] exp);
      bit ok;
      int lat;
      wait_idle();
      set_bin(k, v);
      req = NUM_REQ'(1) << k;
      wait_ack(k, ok);
      req = '0;
      chk("ack_seen", 32'(ok), 32'd1);
      if (!ok) return;
      chk("ack_onehot", 32'(ack), 32'(NUM_REQ'(1) << k));
      chk("busy_at_ack", 32'(busy), 32'd1);
      wait_done(k, ok, lat);
      chk("done_seen", 32'(ok), 32'd1);
      chk("latency", 32'(lat), 32'(LAT));
      chk("done_onehot", 32'(done), 32'(NUM_REQ'(1) << k));
      chk("result", 32'(bcd_out), 32'(exp));
      chk("busy_at_done", 32'(busy), 32'd0);
   endtask

   // Hold a request pattern until n grants are observed; returns log base index
   task automatic run_held(input logic [NUM_REQ-1:0] pat, input int n, output int base);
      bit ok;
      wait_idle();
      base = g_log.size();
      req  = pat;
      ok   = 0;
      for (int i = 0; i < n * 24 + 24; i++) begin
         @(negedge clk);
         if (g_log.size() >= base + n) begin
            ok = 1;
            break;
         end
      end
      req = '0;
      chk("held_timeout", 32'(ok), 32'd1);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bit ok;
      int lat;
      reset  = 1'b0;
      req    = '0;
      bin_in = '0;
      repeat (3) @(negedge clk);
      chk("init_busy", 32'(busy), 32'd0);
      chk("init_gnt",  32'(gnt_id), 32'd0);
      reset = 1'b1;

      run_one(0, 12345, 20'h12345);
      run_one(1, 0,     20'h00000);
      run_one(1, 65535, 20'h65535);
      run_one(1, 9,     20'h00009);
      run_one(1, 10,    20'h00010);

      // Fairness from a fresh pointer
      do_reset();
      for (int k = 0; k < NUM_REQ; k++) set_bin(k, k + 1);
      run_held(4'b1111, 5, base);
      if (g_log.size() >= base + 5) begin
         chk("rr0", 32'(g_log[base+0]), 32'd0);
         chk("rr1", 32'(g_log[base+1]), 32'd1);
         chk("rr2", 32'(g_log[base+2]), 32'd2);
         chk("rr3", 32'(g_log[base+3]), 32'd3);
         chk("rr4", 32'(g_log[base+4]), 32'd0);
         for (int i = 1; i < 5; i++)
            chk("issue_interval", g_cyc[base+i] - g_cyc[base+i-1], 32'(LAT + 1));
      end

      run_one(3, 42, 20'h00042);
      run_held(4'b0101, 2, base);
      if (g_log.size() >= base + 2) begin
         chk("rr_0_before_2", 32'(g_log[base+0]), 32'd0);
         chk("rr_then_2",     32'(g_log[base+1]), 32'd2);
      end
      run_held(4'b0011, 4, base);
      if (g_log.size() >= base + 4) begin
         chk("alt0", 32'(g_log[base+0]), 32'd0);
         chk("alt1", 32'(g_log[base+1]), 32'd1);
         chk("alt2", 32'(g_log[base+2]), 32'd0);
         chk("alt3", 32'(g_log[base+3]), 32'd1);
      end

      // Input changes and short request pulses during a conversion are ignored
      wait_idle();
      set_bin(0, 500);
      req = 4'b0001;
      wait_ack(0, ok);
      req = '0;
      chk("mid_ack", 32'(ok), 32'd1);
      base = g_log.size();
      repeat (3) @(negedge clk);
      set_bin(0, 777);
      @(negedge clk);
      req = 4'b0100;
      @(negedge clk);
      req = '0;
      wait_done(0, ok, lat);
      chk("mid_done", 32'(ok), 32'd1);
      chk("mid_result", 32'(bcd_out), 32'h00500);
      repeat (6) @(negedge clk);
      chk("req2_not_served", 32'(g_log.size()), 32'(base));

      // Abort by reset restores the pointer and suppresses done
      run_one(0, 7, 20'h00007);
      wait_idle();
      set_bin(2, 1234);
      req = 4'b0100;
      wait_ack(2, ok);
      req = '0;
      chk("abort_ack", 32'(ok), 32'd1);
      repeat (8) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_bcd",  32'(bcd_out), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      set_bin(0, 11);
      set_bin(1, 22);
      run_held(4'b0011, 1, base);
      if (g_log.size() >= base + 1)
         chk("ptr_restored", 32'(g_log[base]), 32'd0);
      run_one(1, 22, 20'h00022);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 599) == 0) begin
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
         end
         if ($urandom_range(0, 9) < 3) req = NUM_REQ'($urandom_range(0, 15));
         for (int k = 0; k < NUM_REQ; k++) begin
            case ($urandom_range(0, 7))
               0: set_bin(k, 0);
               1: set_bin(k, 65535);
               2: set_bin(k, $urandom_range(0, 99));
               default: set_bin(k, $urandom_range(0, 65535));
            endcase
         end
      end
      req = '0;
      wait_idle();
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
